sdram_16bit_bram_responder: RTL and testbench

Block RAM–backed responder for the `sdram_16bit` system-side command interface (`sys_CMD`, `sys_ADDR`, `sys_DIN`, `sys_DOUT`, `sys_cmd_ack`, `sys_wr_data_valid`, `sys_rd_data_valid`). It answers burst write and read commands exactly as an initiator expects from the SDRAM controller, including periodic refresh stalls. It drops into a top level in place of `sdram_16bit` so that initiator state machines and OLED hex-display debug tops run without an SDRAM chip.

---
 rtl/sdram_16bit_bram_responder.sv | 195 +++++++++++++++++++
 tb/tb_sdram_16bit_bram_responder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/sdram_16bit_bram_responder.sv
// rtl/sdram_16bit_bram_responder.sv - block-RAM stand-in for the sdram_16bit system-side command interface
// Answers burst writes/reads with the controller's ack/valid timing, including periodic refresh stalls.
module sdram_16bit_bram_responder #(
  parameter int C_addr_bits        = 12,
  parameter int C_wr_latency       = 2,
  parameter int C_rd_latency       = 3,
  parameter int C_refresh_interval = 390,
  parameter int C_refresh_cycles   = 8
) (
  input  logic        sys_CLK,
  input  logic        sys_RESETn,
  input  logic [1:0]  sys_CMD,
  input  logic [22:0] sys_ADDR,
  input  logic [15:0] sys_DIN,
  output logic [15:0] sys_DOUT,
  output logic [1:0]  sys_cmd_ack,
  output logic        sys_wr_data_valid,
  output logic        sys_rd_data_valid,
  output logic        refresh_active
);

  localparam int C_DEPTH = 2 ** C_addr_bits;
  localparam int C_REF_W = $clog2(C_refresh_interval + 1);
  localparam logic [C_REF_W-1:0] C_REF_LAST = C_REF_W'(C_refresh_interval - 1);
  localparam logic [7:0] C_WR_WAIT = 8'(C_wr_latency - 1);
  localparam logic [7:0] C_RD_WAIT = 8'(C_rd_latency - 1);
  localparam logic [7:0] C_REF_CYC = 8'(C_refresh_cycles - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_REFRESH, S_WR_WAIT, S_WR_BURST, S_RD_WAIT, S_RD_BURST
  } state_t;

  state_t                   r_state;
  logic [7:0]               r_cnt;
  logic [1:0]               r_cmd;
  logic [C_addr_bits-1:0]   r_idx;
  logic [1:0]               r_ack;
  logic                     r_wr_valid;
  logic                     r_rd_valid;
  logic                     r_ref_active;
  logic [15:0]              r_dout;
  logic [C_REF_W-1:0]       r_ref_cnt;
  logic                     r_ref_pending;
  logic [15:0]              r_mem [C_DEPTH];

  state_t                   w_state_nxt;
  logic [7:0]               w_cnt_nxt;
  logic [1:0]               w_cmd_nxt;
  logic [C_addr_bits-1:0]   w_idx_nxt;
  logic [1:0]               w_ack_nxt;
  logic                     w_wr_valid_nxt;
  logic                     w_rd_valid_nxt;
  logic                     w_ref_active_nxt;
  logic                     w_pending_clr;
  logic                     w_rd_en;
  logic [7:0]               w_burst_last;
  logic                     w_addr_unused;

  // Only the low address bits index the RAM; the rest wrap away silently.
  assign w_addr_unused = ^sys_ADDR[22:C_addr_bits];
  assign w_burst_last  = (r_cmd == 2'b10) ? 8'd15 : 8'd127;

  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = r_cnt;
    w_cmd_nxt        = r_cmd;
    w_idx_nxt        = r_idx;
    w_ack_nxt        = 2'b00;
    w_wr_valid_nxt   = 1'b0;
    w_rd_valid_nxt   = 1'b0;
    w_ref_active_nxt = 1'b0;
    w_pending_clr    = 1'b0;
    w_rd_en          = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_ref_pending) begin
          w_state_nxt      = S_REFRESH;
          w_cnt_nxt        = C_REF_CYC;
          w_ref_active_nxt = 1'b1;
          w_pending_clr    = 1'b1;
        end else if (sys_CMD != 2'b00) begin
          w_cmd_nxt = sys_CMD;
          w_idx_nxt = sys_ADDR[C_addr_bits-1:0];
          w_ack_nxt = sys_CMD;
          if (sys_CMD == 2'b01) begin
            w_state_nxt = S_WR_WAIT;
            w_cnt_nxt   = C_WR_WAIT;
          end else begin
            w_state_nxt = S_RD_WAIT;
            w_cnt_nxt   = C_RD_WAIT;
          end
        end
      end
      S_REFRESH: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt        = r_cnt - 8'd1;
          w_ref_active_nxt = 1'b1;
        end
      end
      S_WR_WAIT: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt    = S_WR_BURST;
          w_cnt_nxt      = w_burst_last;
          w_wr_valid_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      S_WR_BURST: begin
        w_idx_nxt = r_idx + 1'b1;
        if (r_cnt == 8'd0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt      = r_cnt - 8'd1;
          w_wr_valid_nxt = 1'b1;
        end
      end
      S_RD_WAIT: begin
        if (r_cnt == 8'd0) begin
          w_state_nxt    = S_RD_BURST;
          w_cnt_nxt      = w_burst_last;
          w_rd_valid_nxt = 1'b1;
          w_rd_en        = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 8'd1;
        end
      end
      S_RD_BURST: begin
        // Fetch word k+1 on the edge that ends valid cycle k so valids stay back-to-back.
        if (r_cnt == 8'd0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt      = r_cnt - 8'd1;
          w_idx_nxt      = r_idx + 1'b1;
          w_rd_valid_nxt = 1'b1;
          w_rd_en        = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_CLK or negedge sys_RESETn) begin
    if (!sys_RESETn) begin
      r_state       <= S_IDLE;
      r_cnt         <= 8'd0;
      r_cmd         <= 2'b00;
      r_idx         <= '0;
      r_ack         <= 2'b00;
      r_wr_valid    <= 1'b0;
      r_rd_valid    <= 1'b0;
      r_ref_active  <= 1'b0;
      r_dout        <= 16'h0000;
      r_ref_cnt     <= '0;
      r_ref_pending <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_cmd        <= w_cmd_nxt;
      r_idx        <= w_idx_nxt;
      r_ack        <= w_ack_nxt;
      r_wr_valid   <= w_wr_valid_nxt;
      r_rd_valid   <= w_rd_valid_nxt;
      r_ref_active <= w_ref_active_nxt;
      if (w_rd_en) begin
        r_dout <= r_mem[w_idx_nxt];
      end
      if (r_ref_cnt == C_REF_LAST) begin
        r_ref_cnt     <= '0;
        r_ref_pending <= 1'b1;
      end else begin
        r_ref_cnt <= r_ref_cnt + 1'b1;
        if (w_pending_clr) begin
          r_ref_pending <= 1'b0;
        end
      end
    end
  end

  // RAM contents survive reset; a cleared valid stops any further writes immediately.
  always_ff @(posedge sys_CLK) begin
    if (r_wr_valid) begin
      r_mem[r_idx] <= sys_DIN;
    end
  end

  assign sys_DOUT          = r_dout;
  assign sys_cmd_ack       = r_ack;
  assign sys_wr_data_valid = r_wr_valid;
  assign sys_rd_data_valid = r_rd_valid;
  assign refresh_active    = r_ref_active;

endmodule

// File: tb/tb_sdram_16bit_bram_responder.sv
// tb/tb_sdram_16bit_bram_responder.sv - directed/randomized bench for sdram_16bit_bram_responder
// Word-array reference model of RAM contents; timing expectations taken from the ack/valid rules.
module tb_sdram_16bit_bram_responder;

  localparam int DEPTH = 4096;
  localparam int WL    = 2;
  localparam int RL    = 3;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  cmd   = 2'b00;
  logic [22:0] addr  = '0;
  logic [15:0] din   = '0;
  logic [15:0] dout;
  logic [1:0]  ack;
  logic        wr_v;
  logic        rd_v;
  logic        ref_act;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] ref_mem [DEPTH];
  logic [15:0] wdata [128];
  logic [15:0] exp_dout = 16'h0000;

  always #5 clk = ~clk;

  sdram_16bit_bram_responder dut (
    .sys_CLK           (clk),
    .sys_RESETn        (rst_n),
    .sys_CMD           (cmd),
    .sys_ADDR          (addr),
    .sys_DIN           (din),
    .sys_DOUT          (dout),
    .sys_cmd_ack       (ack),
    .sys_wr_data_valid (wr_v),
    .sys_rd_data_valid (rd_v),
    .refresh_active    (ref_act)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts at the negedge of the ack cycle; follows the burst to the first idle cycle after it.
  task automatic check_burst(input logic [1:0] c, input logic [22:0] a, input int abort_at);
    int n;
    int lat;
    int k;
    int idx;
    n   = (c == 2'b10) ? 16 : 128;
    lat = (c == 2'b01) ? WL : RL;
    for (int j = 1; j <= lat + n; j++) begin
      @(negedge clk);
      k   = j - lat;
      idx = (int'(a) + k) % DEPTH;
      check("ack_one_cycle", 32'(ack), 32'(2'b00));
      if (c == 2'b01) begin
        check("wr_valid", 32'(wr_v), 32'((k >= 0) && (k < n)));
        check("rd_valid_in_write", 32'(rd_v), 32'(0));
        if (k >= 0 && k < n) begin
          if (k == abort_at) begin
            rst_n = 1'b0;
            #1;
            check("abort_wr_valid", 32'(wr_v), 32'(0));
            check("abort_rd_valid", 32'(rd_v), 32'(0));
            check("abort_ack", 32'(ack), 32'(0));
            check("abort_dout", 32'(dout), 32'(0));
            check("abort_refresh", 32'(ref_act), 32'(0));
            exp_dout = 16'h0000;
            return;
          end
          din          = wdata[k];
          ref_mem[idx] = wdata[k];
        end
      end else begin
        check("rd_valid", 32'(rd_v), 32'((k >= 0) && (k < n)));
        check("wr_valid_in_read", 32'(wr_v), 32'(0));
        if (k >= 0 && k < n) begin
          exp_dout = ref_mem[idx];
          check("rd_data", 32'(dout), 32'(exp_dout));
        end else begin
          check("dout_hold", 32'(dout), 32'(exp_dout));
        end
      end
    end
  endtask

  task automatic run_cmd(input logic [1:0] c, input logic [22:0] a, input bit chk_lat,
                         input bit hold, input int abort_at);
    int waited;
    waited = 0;
    @(posedge clk);
    #1;
    cmd  = c;
    addr = a;
    do begin
      @(negedge clk);
      waited++;
    end while (ack == 2'b00 && waited < 2000);
    check("ack_value", 32'(ack), 32'(c));
    if (chk_lat) check("ack_latency", 32'(waited), 32'(2));
    if (!hold) cmd = 2'b00;
    check_burst(c, a, abort_at);
  endtask

  // Returns at the first idle negedge after a refresh stall.
  task automatic resync();
    int w;
    w = 0;
    while (ref_act !== 1'b1 && w < 1000) begin @(negedge clk); w++; end
    check("resync_rise", 32'(ref_act), 32'(1));
    w = 0;
    while (ref_act !== 1'b0 && w < 20) begin @(negedge clk); w++; end
    check("resync_fall", 32'(ref_act), 32'(0));
  endtask

  initial begin
    logic [22:0] a;

    repeat (3) @(negedge clk);
    check("rst_dout", 32'(dout), 32'(0));
    check("rst_ack", 32'(ack), 32'(0));
    check("rst_wr_valid", 32'(wr_v), 32'(0));
    check("rst_rd_valid", 32'(rd_v), 32'(0));
    check("rst_refresh", 32'(ref_act), 32'(0));
    rst_n = 1'b1;

    // Write k to 0..127, read back 16 words.
    for (int k = 0; k < 128; k++) wdata[k] = 16'(k);
    run_cmd(2'b01, 23'h000000, 1'b1, 1'b0, -1);
    run_cmd(2'b10, 23'h000000, 1'b1, 1'b0, -1);

    // Burst crossing the top of the RAM, with and without a high address bit.
    for (int k = 0; k < 128; k++) wdata[k] = 16'hA000 + 16'(k);
    run_cmd(2'b01, 23'h000FC0, 1'b0, 1'b0, -1);
    run_cmd(2'b11, 23'h000FC0, 1'b0, 1'b0, -1);
    run_cmd(2'b10, 23'h000000, 1'b0, 1'b0, -1);
    check("wrap_index0", 32'(ref_mem[0]), 32'(16'hA040));
    run_cmd(2'b11, 23'h400FC0, 1'b0, 1'b0, -1);

    // Read command raised right after the refresh counter wraps.
    resync();
    resync();
    repeat (381) @(posedge clk);
    #1;
    a    = 23'(16'hA000 + 16'($urandom_range(0, 63)));
    a    = 23'h000FC0 + 23'($urandom_range(0, 112));
    cmd  = 2'b10;
    addr = a;
    for (int j = 1; j <= 11; j++) begin
      @(negedge clk);
      check("refresh_window_active", 32'(ref_act), 32'((j >= 2) && (j <= 9)));
      check("refresh_window_ack", 32'(ack), (j == 11) ? 32'(2'b10) : 32'(0));
    end
    cmd = 2'b00;
    check_burst(2'b10, a, -1);

    // Command held across a whole burst is accepted a second time.
    resync();
    a = 23'($urandom_range(0, 112));
    run_cmd(2'b10, a, 1'b1, 1'b1, -1);
    @(negedge clk);
    check("held_second_ack", 32'(ack), 32'(2'b10));
    cmd = 2'b00;
    check_burst(2'b10, a, -1);

    // Random bases and data.
    for (int r = 0; r < 3; r++) begin
      a = 23'($urandom);
      for (int k = 0; k < 128; k++) wdata[k] = 16'($urandom);
      run_cmd(2'b01, a, 1'b0, 1'b0, -1);
      run_cmd(2'b11, a, 1'b0, 1'b0, -1);
      run_cmd(2'b10, a + 23'($urandom_range(0, 112)), 1'b0, 1'b0, -1);
    end

    // Reset during word 50 of a write over previously written data.
    a = 23'($urandom);
    for (int k = 0; k < 128; k++) wdata[k] = 16'($urandom);
    run_cmd(2'b01, a, 1'b0, 1'b0, -1);
    for (int k = 0; k < 128; k++) wdata[k] = ~wdata[k];
    run_cmd(2'b01, a, 1'b0, 1'b0, 50);
    repeat (2) @(negedge clk);
    check("reset_hold_wr_valid", 32'(wr_v), 32'(0));
    rst_n = 1'b1;
    run_cmd(2'b11, a, 1'b1, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
